// File: rtl/regfile_mp.sv
// regfile_mp: 2-read/2-write register file with write bypass, optional zero register and bulk-clear sweep
module regfile_mp #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_enable2,
  input  logic [ADDR_W-1:0] rd2,
  input  logic [DATA_W-1:0] write_data2,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t            state_q;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [ADDR_W-1:0] cnt_q;
  logic              done_q;
  logic              we0, we1;
  assign busy       = state_q == CLEAR;
  assign clear_done = done_q;
  // effective write strobes: nothing commits during a sweep or into a hardwired zero register
  always_comb begin
    we0 = write_enable && !busy && !(ZERO_REG != 0 && rd == '0);
    we1 = write_enable2 && !busy && !(ZERO_REG != 0 && rd2 == '0);
  end
  // combinational reads; forwarded data uses the same port-0-first priority as the commit
  always_comb begin
    read_data1 = (ZERO_REG != 0 && rs == '0) ? '0 :
                 (BYPASS != 0 && we0 && rd == rs) ? write_data :
                 (BYPASS != 0 && we1 && rd2 == rs) ? write_data2 : regs_q[rs];
    read_data2 = (ZERO_REG != 0 && rt == '0) ? '0 :
                 (BYPASS != 0 && we0 && rd == rt) ? write_data :
                 (BYPASS != 0 && we1 && rd2 == rt) ? write_data2 : regs_q[rt];
  end
  // array commit plus clear sweep; port 0 is assigned last so it wins a same-address collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (we1) regs_q[rd2] <= write_data2;
      if (we0) regs_q[rd] <= write_data;
      if (state_q == IDLE) begin
        if (clear_req) begin
          state_q <= CLEAR;
          cnt_q   <= '0;
        end
      end else begin
        regs_q[cnt_q] <= '0;
        cnt_q         <= cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH-1)) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          done_q  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp with directed vectors
module tb_regfile_mp;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       write_enable = 1'b0, write_enable2 = 1'b0, clear_req = 1'b0;
  logic [4:0] rd = '0, rd2 = '0, rs = '0, rt = '0;
  logic [7:0] write_data = '0, write_data2 = '0;
  logic [7:0] read_data1, read_data2;
  logic       busy, clear_done;
  typedef struct packed {logic [7:0] d1; logic [7:0] d2; logic b; logic c;} exp_t;
  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0, failures = 0;

  regfile_mp dut (
    .clk(clk), .rst_n(rst_n),
    .write_enable(write_enable), .rd(rd), .write_data(write_data),
    .write_enable2(write_enable2), .rd2(rd2), .write_data2(write_data2),
    .rs(rs), .rt(rt), .read_data1(read_data1), .read_data2(read_data2),
    .clear_req(clear_req), .busy(busy), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input string n, input logic [7:0] d1, input logic [7:0] d2, input logic b, input logic c);
    exp_q.push_back(exp_t'({d1, d2, b, c}));
    name_q.push_back(n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: outputs are settled mid-cycle, so every queued expectation is compared on the falling edge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if ({read_data1, read_data2, busy, clear_done} !== {e.d1, e.d2, e.b, e.c}) begin
        failures++;
        $display("FAIL %s: got rd1=%h rd2=%h busy=%b done=%b, want rd1=%h rd2=%h busy=%b done=%b",
                 n, read_data1, read_data2, busy, clear_done, e.d1, e.d2, e.b, e.c);
      end
    end
  end

  initial begin
    // reset state swept over every address
    for (int i = 0; i < 32; i++) begin
      tick();
      rs = 5'(i); rt = 5'(31 - i);
      push_exp("reset", 8'h00, 8'h00, 1'b0, 1'b0);
    end
    tick();
    rst_n = 1'b1;
    // basic write with bypass, then registered read
    tick();
    write_enable = 1'b1; rd = 5'd5; write_data = 8'hEF; rs = 5'd5; rt = 5'd5;
    push_exp("bypass5", 8'hEF, 8'hEF, 1'b0, 1'b0);
    tick();
    write_enable = 1'b0;
    push_exp("read5", 8'hEF, 8'hEF, 1'b0, 1'b0);
    // zero register: no forward, no commit
    tick();
    write_enable = 1'b1; rd = 5'd0; write_data = 8'hFF; rs = 5'd0; rt = 5'd0;
    push_exp("zero_byp", 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    rd = 5'd7; write_data = 8'h3C; rs = 5'd7; rt = 5'd0;
    push_exp("byp7_zero", 8'h3C, 8'h00, 1'b0, 1'b0);
    tick();
    write_enable = 1'b0; rs = 5'd7; rt = 5'd7;
    push_exp("read7", 8'h3C, 8'h3C, 1'b0, 1'b0);
    // dual-write collision: port 0 wins in both bypass and commit
    tick();
    write_enable = 1'b1; rd = 5'd9; write_data = 8'hAA;
    write_enable2 = 1'b1; rd2 = 5'd9; write_data2 = 8'h55; rs = 5'd9; rt = 5'd9;
    push_exp("dual_byp", 8'hAA, 8'hAA, 1'b0, 1'b0);
    tick();
    write_enable = 1'b0; rd2 = 5'd12; write_data2 = 8'h66; rs = 5'd9; rt = 5'd12;
    push_exp("dual_reg_p1byp", 8'hAA, 8'h66, 1'b0, 1'b0);
    tick();
    rd2 = 5'd0; write_data2 = 8'h11; rs = 5'd12; rt = 5'd0;
    push_exp("p1_read_zero", 8'h66, 8'h00, 1'b0, 1'b0);
    tick();
    write_enable2 = 1'b0; rs = 5'd0; rt = 5'd5;
    push_exp("zero_kept", 8'h00, 8'hEF, 1'b0, 1'b0);
    // fill 1..31 with 0x40+i
    for (int i = 1; i < 32; i++) begin
      tick();
      write_enable = 1'b1; rd = 5'(i); write_data = 8'(8'h40 + i); rs = 5'(i); rt = 5'(i - 1);
      push_exp("fill", 8'(8'h40 + i), (i == 1) ? 8'h00 : 8'(8'h40 + i - 1), 1'b0, 1'b0);
    end
    tick();
    write_enable = 1'b0; clear_req = 1'b1; rs = 5'd31; rt = 5'd3;
    push_exp("pre_clear", 8'h5F, 8'h43, 1'b0, 1'b0);
    tick();
    // sweep: reg s is zeroed at the end of sweep cycle s; writes and clear_req are ignored
    for (int s = 0; s < 32; s++) begin
      write_enable = (s == 10); rd = 5'd3; write_data = 8'h77;
      clear_req = (s == 5);
      rs = (s == 10) ? 5'd3 : 5'd31; rt = 5'd3;
      push_exp("sweep", (s == 10) ? 8'h00 : 8'h5F, (s >= 4) ? 8'h00 : 8'h43, 1'b1, 1'b0);
      tick();
    end
    write_enable = 1'b0; clear_req = 1'b0; rs = 5'd3; rt = 5'd31;
    push_exp("clear_done", 8'h00, 8'h00, 1'b0, 1'b1);
    tick();
    push_exp("done_pulse_end", 8'h00, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      tick();
      rs = 5'(i); rt = 5'(31 - i);
      push_exp("cleared", 8'h00, 8'h00, 1'b0, 1'b0);
    end
    // reset in the middle of a sweep
    tick();
    write_enable = 1'b1; rd = 5'd20; write_data = 8'h99;
    write_enable2 = 1'b1; rd2 = 5'd21; write_data2 = 8'h98;
    tick();
    write_enable = 1'b0; write_enable2 = 1'b0; clear_req = 1'b1; rs = 5'd20; rt = 5'd21;
    push_exp("pre_clear2", 8'h99, 8'h98, 1'b0, 1'b0);
    tick();
    clear_req = 1'b0;
    for (int s = 0; s < 10; s++) begin
      push_exp("sweep2", 8'h99, 8'h98, 1'b1, 1'b0);
      tick();
    end
    rst_n = 1'b0;
    #1;
    push_exp("rst_mid", 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    push_exp("rst_hold", 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_exp("post_rst", 8'h00, 8'h00, 1'b0, 1'b0);
      tick();
    end
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
